// File: rtl/scalar_operand_resolver_pkg.sv
// ---------------------------------------------------------------------------
// scalar_operand_resolver_pkg
//
// Shared definitions for the scalar operand resolver:
//   - prefixes of the 12-bit internal operand encoding
//   - the fp-constant / literal marker
//   - one-hot codes selecting a special register
//   - FSM state and operand-kind enumerations
//   - a small sign-extension helper for inline integer constants
// ---------------------------------------------------------------------------
package scalar_operand_resolver_pkg;

  // Operand encoding prefixes
  localparam logic [1:0]  PFX_VGPR    = 2'b10;
  localparam logic [2:0]  PFX_SGPR    = 3'b110;
  localparam logic [2:0]  PFX_SPECIAL = 3'b111;
  localparam logic [1:0]  PFX_INT     = 2'b00;

  // Shared marker for "fp constant or instruction literal"
  localparam logic [11:0] OPND_FP_LIT = 12'h7FF;

  // Special register selectors, one-hot in operand bits [8:0]
  localparam logic [8:0] SPC_VCC_LO  = 9'd1;
  localparam logic [8:0] SPC_VCC_HI  = 9'd2;
  localparam logic [8:0] SPC_M0      = 9'd4;
  localparam logic [8:0] SPC_EXEC_LO = 9'd8;
  localparam logic [8:0] SPC_EXEC_HI = 9'd16;
  localparam logic [8:0] SPC_VCCZ    = 9'd32;
  localparam logic [8:0] SPC_EXECZ   = 9'd64;
  localparam logic [8:0] SPC_SCC     = 9'd128;

  // Resolver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_WAIT_LO,
    ST_RD_HI,
    ST_WAIT_HI,
    ST_RESP
  } state_t;

  // What the decoder found: either a value available immediately or an SGPR
  // that still has to be read from the register file.
  typedef enum logic {
    KIND_VALUE,
    KIND_SGPR
  } opnd_kind_t;

  // Sign-extend a 10-bit inline integer to 64 bits, or to 32 bits with the
  // upper word cleared when the operand is narrow.
  function automatic logic [63:0] sext_inline(input logic [9:0] imm, input logic wide);
    logic [63:0] full;
    full = {{54{imm[9]}}, imm};
    return wide ? full : {32'h0, full[31:0]};
  endfunction

endpackage

// File: rtl/scalar_operand_resolver_decode.sv
// ---------------------------------------------------------------------------
// scalar_operand_decode
//
// Purely combinational classification of one encoded scalar operand.
// Produces an immediate value for everything that does not need an SGPR read,
// the SGPR address when one is needed, and an error flag for illegal or
// unresolvable encodings.
//
// Ports:
//   opnd              in  12  encoded operand
//   wide              in  1   1 = 64-bit operand
//   fp_constant       in  33  [32] valid, [31:0] IEEE pattern
//   literal_required  in  1   operand is the instruction literal
//   literal           in  32  literal dword
//   vcc, exec         in  64  current VCC / EXEC
//   m0                in  32  current M0
//   scc               in  1   current SCC
//   kind              out     KIND_VALUE or KIND_SGPR
//   error             out 1   illegal / unresolvable encoding
//   value             out 64  resolved immediate value (0 on error)
//   sgpr_addr         out 9   SGPR dword address
// ---------------------------------------------------------------------------
module scalar_operand_decode
  import scalar_operand_resolver_pkg::*;
(
  input  logic [11:0] opnd,
  input  logic        wide,
  input  logic [32:0] fp_constant,
  input  logic        literal_required,
  input  logic [31:0] literal,
  input  logic [63:0] vcc,
  input  logic [63:0] exec,
  input  logic [31:0] m0,
  input  logic        scc,
  output opnd_kind_t  kind,
  output logic        error,
  output logic [63:0] value,
  output logic [8:0]  sgpr_addr
);

  // Classify the operand by prefix. The fp/literal marker has [11:10]=01, so
  // it is checked first and every other 01-prefixed code falls to error.
  // Wide reads of registers that only have 32 meaningful bits (VCC_HI,
  // EXEC_HI, M0) are rejected, as are wide SGPR pairs that are not aligned.
  // Any error forces the value to zero so the response carries no stale data.
  always_comb begin
    kind      = KIND_VALUE;
    error     = 1'b0;
    value     = 64'h0;
    sgpr_addr = opnd[8:0];

    if (opnd == OPND_FP_LIT) begin
      if (literal_required) begin
        value = {32'h0, literal};
      end else if (fp_constant[32]) begin
        value = {32'h0, fp_constant[31:0]};
      end else begin
        error = 1'b1;
      end
    end else if (opnd[11:10] == PFX_INT) begin
      value = sext_inline(opnd[9:0], wide);
    end else if (opnd[11:10] == PFX_VGPR) begin
      error = 1'b1;
    end else if (opnd[11:9] == PFX_SGPR) begin
      kind = KIND_SGPR;
      if (wide && opnd[0]) begin
        error = 1'b1;
      end
    end else if (opnd[11:9] == PFX_SPECIAL) begin
      case (opnd[8:0])
        SPC_VCC_LO:  value = wide ? vcc : {32'h0, vcc[31:0]};
        SPC_VCC_HI:  begin
          if (wide) error = 1'b1;
          else      value = {32'h0, vcc[63:32]};
        end
        SPC_M0:      begin
          if (wide) error = 1'b1;
          else      value = {32'h0, m0};
        end
        SPC_EXEC_LO: value = wide ? exec : {32'h0, exec[31:0]};
        SPC_EXEC_HI: begin
          if (wide) error = 1'b1;
          else      value = {32'h0, exec[63:32]};
        end
        SPC_VCCZ:    value = {63'h0, (vcc == 64'h0)};
        SPC_EXECZ:   value = {63'h0, (exec == 64'h0)};
        SPC_SCC:     value = {63'h0, scc};
        default:     error = 1'b1;
      endcase
    end else begin
      error = 1'b1;
    end

    if (error) begin
      kind  = KIND_VALUE;
      value = 64'h0;
    end
  end

endmodule

// File: rtl/scalar_operand_resolver.sv
// ---------------------------------------------------------------------------
// scalar_operand_resolver
//
// Resolves one encoded scalar source operand into its 32- or 64-bit value.
// Immediate kinds (constants, literal, special registers) answer one cycle
// after acceptance; SGPR operands are read from the register file, one dword
// for narrow operands and an aligned pair for wide ones.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_opnd              encoded operand (12)
//   req_wide              1 = 64-bit operand
//   req_fp_constant       [32] valid, [31:0] IEEE pattern
//   req_literal_required  operand is the instruction literal
//   req_literal           literal dword
//   sgpr_rd_en/addr       registered SGPR read strobe and dword address
//   sgpr_rd_data          SGPR read data, SGPR_RD_LATENCY cycles after strobe
//   vcc, exec, m0, scc    current special register values
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              resolved value (upper word zero when narrow)
//   rsp_error             illegal or unresolvable encoding
// ---------------------------------------------------------------------------
module scalar_operand_resolver
  import scalar_operand_resolver_pkg::*;
#(
  parameter int unsigned SGPR_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_opnd,
  input  logic        req_wide,
  input  logic [32:0] req_fp_constant,
  input  logic        req_literal_required,
  input  logic [31:0] req_literal,
  output logic        sgpr_rd_en,
  output logic [8:0]  sgpr_rd_addr,
  input  logic [31:0] sgpr_rd_data,
  input  logic [63:0] vcc,
  input  logic [63:0] exec,
  input  logic [31:0] m0,
  input  logic        scc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_error
);

  // Wait-state count at which read data is present, and the extra turnaround
  // count after which the high read of a wide pair is issued.
  localparam logic [2:0] LAST_BEAT = 3'(SGPR_RD_LATENCY - 1);
  localparam logic [2:0] TURN_BEAT = 3'(SGPR_RD_LATENCY);

  state_t      state;
  state_t      next_state;
  logic [2:0]  lat_cnt;
  logic        is_wide;
  logic        accept;
  logic        capture_lo;
  logic        capture_hi;

  opnd_kind_t  dec_kind;
  logic        dec_error;
  logic [63:0] dec_value;
  logic [8:0]  dec_sgpr_addr;

  scalar_operand_decode u_decode (
    .opnd             (req_opnd),
    .wide             (req_wide),
    .fp_constant      (req_fp_constant),
    .literal_required (req_literal_required),
    .literal          (req_literal),
    .vcc              (vcc),
    .exec             (exec),
    .m0               (m0),
    .scc              (scc),
    .kind             (dec_kind),
    .error            (dec_error),
    .value            (dec_value),
    .sgpr_addr        (dec_sgpr_addr)
  );

  assign accept     = req_valid && (state == ST_IDLE);
  assign capture_lo = (state == ST_WAIT_LO) && (lat_cnt == LAST_BEAT);
  assign capture_hi = (state == ST_WAIT_HI) && (lat_cnt == LAST_BEAT);

  // State register: reset abandons whatever read was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A wide operand lingers in WAIT_LO one cycle past the
  // low capture so the high read goes out one cycle after the low word has
  // been registered.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_kind == KIND_SGPR) next_state = ST_RD_LO;
          else                       next_state = ST_RESP;
        end
      end
      ST_RD_LO:   next_state = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!is_wide && lat_cnt == LAST_BEAT)     next_state = ST_RESP;
        else if (is_wide && lat_cnt == TURN_BEAT) next_state = ST_RD_HI;
      end
      ST_RD_HI:   next_state = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (lat_cnt == LAST_BEAT) next_state = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) next_state = ST_IDLE;
      end
      default:    next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs follow directly from the state.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  // Latency counter: cleared on each read strobe, counts through the wait
  // states so capture lines up with the register file latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= 3'd0;
    end else if (state == ST_WAIT_LO || state == ST_WAIT_HI) begin
      lat_cnt <= lat_cnt + 3'd1;
    end else begin
      lat_cnt <= 3'd0;
    end
  end

  // Read port: the strobe is registered from the next state so it is high
  // exactly while the FSM sits in RD_LO or RD_HI. The address is loaded on
  // acceptance and stepped to the odd partner before the high read.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgpr_rd_en   <= 1'b0;
      sgpr_rd_addr <= 9'd0;
    end else begin
      sgpr_rd_en <= (next_state == ST_RD_LO) || (next_state == ST_RD_HI);
      if (accept && dec_kind == KIND_SGPR) begin
        sgpr_rd_addr <= dec_sgpr_addr;
      end else if (state == ST_WAIT_LO && next_state == ST_RD_HI) begin
        sgpr_rd_addr <= sgpr_rd_addr + 9'd1;
      end
    end
  end

  // Response datapath: immediates and errors are latched at acceptance, which
  // also samples the special registers in the request cycle. SGPR responses
  // start from zero and are filled one dword at a time. Nothing changes while
  // the response waits for rsp_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data  <= 64'h0;
      rsp_error <= 1'b0;
      is_wide   <= 1'b0;
    end else begin
      if (accept) begin
        is_wide   <= req_wide;
        rsp_error <= dec_error;
        if (dec_kind == KIND_SGPR) rsp_data <= 64'h0;
        else                       rsp_data <= dec_value;
      end
      if (capture_lo) begin
        rsp_data[31:0] <= sgpr_rd_data;
      end
      if (capture_hi) begin
        rsp_data[63:32] <= sgpr_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_scalar_operand_resolver.sv
// ---------------------------------------------------------------------------
// tb_scalar_operand_resolver
//
// Directed testbench for scalar_operand_resolver with a scoreboard: stimulus
// pushes expected responses and expected SGPR reads into queues, and a
// monitor on the falling edge pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_scalar_operand_resolver;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_opnd;
  logic        req_wide;
  logic [32:0] req_fp_constant;
  logic        req_literal_required;
  logic [31:0] req_literal;
  logic        sgpr_rd_en;
  logic [8:0]  sgpr_rd_addr;
  logic [31:0] sgpr_rd_data;
  logic [63:0] vcc;
  logic [63:0] exec;
  logic [31:0] m0;
  logic        scc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_error;

  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;

  // Scoreboard queues
  logic [63:0] exp_data_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];
  string       exp_name_q[$];
  logic [8:0]  rd_addr_q[$];
  int          rd_cyc_q[$];

  // SGPR file model with a fixed read pipeline
  logic [31:0] sgpr_mem [512];
  logic        pipe_vld [8];
  logic [8:0]  pipe_addr [8];

  scalar_operand_resolver #(.SGPR_RD_LATENCY(LAT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_opnd             (req_opnd),
    .req_wide             (req_wide),
    .req_fp_constant      (req_fp_constant),
    .req_literal_required (req_literal_required),
    .req_literal          (req_literal),
    .sgpr_rd_en           (sgpr_rd_en),
    .sgpr_rd_addr         (sgpr_rd_addr),
    .sgpr_rd_data         (sgpr_rd_data),
    .vcc                  (vcc),
    .exec                 (exec),
    .m0                   (m0),
    .scc                  (scc),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_data             (rsp_data),
    .rsp_error            (rsp_error)
  );

  // Free-running clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file read pipeline: data for a strobe seen in one cycle shows
  // up LAT cycles later; between reads a poison pattern is driven.
  always @(posedge clk) begin
    pipe_vld[0]  <= sgpr_rd_en;
    pipe_addr[0] <= sgpr_rd_addr;
    for (int k = 1; k < 8; k++) begin
      pipe_vld[k]  <= pipe_vld[k-1];
      pipe_addr[k] <= pipe_addr[k-1];
    end
  end

  assign sgpr_rd_data = pipe_vld[LAT-1] ? sgpr_mem[pipe_addr[LAT-1]] : 32'hBAD0_BAD0;

  // Single comparison point shared by the main flow and the monitor
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one request, wait for acceptance, record expectations, then
  // scramble the request-side inputs for a cycle to show they are not reused.
  task automatic applyStimulus(input string name, input logic [11:0] opnd, input logic wide,
                               input logic [32:0] fpc, input logic litreq, input logic [31:0] lit,
                               input logic [63:0] exp_data, input logic exp_err, input int exp_lat,
                               input int nrd, input logic [8:0] rd_base);
    int          guard;
    logic [63:0] s_vcc;
    logic [63:0] s_exec;
    logic [31:0] s_m0;
    logic        s_scc;
    @(negedge clk);
    req_opnd             = opnd;
    req_wide             = wide;
    req_fp_constant      = fpc;
    req_literal_required = litreq;
    req_literal          = lit;
    req_valid            = 1'b1;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      tests_run++;
      failed++;
      $display("[TB] FAIL %s accept: req_ready stayed 0, required 1 within 100 cycles", name);
      req_valid = 1'b0;
      return;
    end
    exp_data_q.push_back(exp_data);
    exp_err_q.push_back(exp_err);
    exp_cyc_q.push_back(cyc + exp_lat);
    exp_name_q.push_back(name);
    if (nrd >= 1) begin
      rd_addr_q.push_back(rd_base);
      rd_cyc_q.push_back(cyc + 1);
    end
    if (nrd >= 2) begin
      rd_addr_q.push_back(rd_base + 9'd1);
      rd_cyc_q.push_back(cyc + LAT + 3);
    end
    s_vcc = vcc; s_exec = exec; s_m0 = m0; s_scc = scc;
    @(posedge clk);
    #1;
    req_valid            = 1'b0;
    req_opnd             = 12'hA10;
    req_wide             = ~wide;
    req_fp_constant      = ~fpc;
    req_literal_required = ~litreq;
    req_literal          = ~lit;
    vcc = ~s_vcc; exec = ~s_exec; m0 = ~s_m0; scc = ~s_scc;
    @(posedge clk);
    #1;
    vcc = s_vcc; exec = s_exec; m0 = s_m0; scc = s_scc;
  endtask

  // Monitor: checks read strobes against expected reads, response stability
  // under backpressure, and each handshaken response against the scoreboard.
  logic [63:0] hold_data;
  logic        hold_err;
  logic        holding = 1'b0;
  logic        chk_ready_next = 1'b0;
  int          first_cyc;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_ready_next) begin
        checkOutput("req_ready after handshake", {63'h0, req_ready}, 64'h1);
        chk_ready_next = 1'b0;
      end
      if (sgpr_rd_en) begin
        if (rd_addr_q.size() == 0) begin
          tests_run++;
          failed++;
          $display("[TB] FAIL unexpected sgpr_rd_en: got addr 0x%0h at cycle %0d, required no read", sgpr_rd_addr, cyc);
        end else begin
          checkOutput("sgpr_rd_addr", {55'h0, sgpr_rd_addr}, {55'h0, rd_addr_q.pop_front()});
          checkOutput("sgpr_rd_en cycle", 64'(cyc), 64'(rd_cyc_q.pop_front()));
        end
      end
      if (rsp_valid) begin
        checkOutput("req_ready while responding", {63'h0, req_ready}, 64'h0);
        if (!holding) begin
          holding   = 1'b1;
          hold_data = rsp_data;
          hold_err  = rsp_error;
          first_cyc = cyc;
        end else begin
          checkOutput("rsp_data stable", rsp_data, hold_data);
          checkOutput("rsp_error stable", {63'h0, rsp_error}, {63'h0, hold_err});
        end
        if (rsp_ready) begin
          holding = 1'b0;
          chk_ready_next = 1'b1;
          if (exp_data_q.size() == 0) begin
            tests_run++;
            failed++;
            $display("[TB] FAIL unexpected response: got 0x%0h err %0b, required none", rsp_data, rsp_error);
          end else begin
            string nm;
            nm = exp_name_q.pop_front();
            checkOutput({nm, " data"}, rsp_data, exp_data_q.pop_front());
            checkOutput({nm, " error"}, {63'h0, rsp_error}, {63'h0, exp_err_q.pop_front()});
            checkOutput({nm, " latency"}, 64'(first_cyc), 64'(exp_cyc_q.pop_front()));
          end
        end
      end
    end
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [32:0] FP_NONE = 33'h0;
  localparam logic [32:0] FP_ONE  = {1'b1, 32'h3F80_0000};

  initial begin
    int guard;
    for (int i = 0; i < 512; i++) sgpr_mem[i] = 32'hA500_0000 | i;
    sgpr_mem[7]     = 32'hDEAD_BEEF;
    sgpr_mem[9'h1FE] = 32'h1111_2222;
    sgpr_mem[9'h1FF] = 32'h3333_4444;

    rst = 1'b1; req_valid = 1'b0; req_opnd = 12'h0; req_wide = 1'b0;
    req_fp_constant = 33'h0; req_literal_required = 1'b0; req_literal = 32'h0;
    vcc = 64'h0; exec = 64'hF; m0 = 32'hCAFE_F00D; scc = 1'b1; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset req_ready",    {63'h0, req_ready},  64'h1);
    checkOutput("reset rsp_valid",    {63'h0, rsp_valid},  64'h0);
    checkOutput("reset rsp_data",     rsp_data,            64'h0);
    checkOutput("reset rsp_error",    {63'h0, rsp_error},  64'h0);
    checkOutput("reset sgpr_rd_en",   {63'h0, sgpr_rd_en}, 64'h0);
    checkOutput("reset sgpr_rd_addr", {55'h0, sgpr_rd_addr}, 64'h0);

    // Inline integer constants
    applyStimulus("int 5",          12'h005, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h5, 1'b0, 1, 0, 9'h0);
    applyStimulus("int -1 wide",    12'h3FF, 1'b1, FP_NONE, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 0, 9'h0);
    applyStimulus("int -512",       12'h200, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0000_0000_FFFF_FE00, 1'b0, 1, 0, 9'h0);
    applyStimulus("int 511 wide",   12'h1FF, 1'b1, FP_NONE, 1'b0, 32'h0, 64'h1FF, 1'b0, 1, 0, 9'h0);

    // SGPR reads (LAT=2: narrow response at +4, wide at +8)
    applyStimulus("sgpr narrow",    12'hC07, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, LAT + 2, 1, 9'h007);
    applyStimulus("sgpr wide",      12'hDFE, 1'b1, FP_NONE, 1'b0, 32'h0, 64'h3333_4444_1111_2222, 1'b0, 2*LAT + 4, 2, 9'h1FE);
    applyStimulus("sgpr wide odd",  12'hDFF, 1'b1, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b1, 1, 0, 9'h0);
    applyStimulus("sgpr narrow odd",12'hDFF, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0000_0000_3333_4444, 1'b0, LAT + 2, 1, 9'h1FF);

    // Specials with vcc=0, exec=0xF
    applyStimulus("vccz",           12'hE20, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h1, 1'b0, 1, 0, 9'h0);
    applyStimulus("exec_lo wide",   12'hE08, 1'b1, FP_NONE, 1'b0, 32'h0, 64'hF, 1'b0, 1, 0, 9'h0);
    applyStimulus("execz nonzero",  12'hE40, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b0, 1, 0, 9'h0);
    applyStimulus("scc",            12'hE80, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h1, 1'b0, 1, 0, 9'h0);
    applyStimulus("not one-hot",    12'hE03, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b1, 1, 0, 9'h0);
    applyStimulus("special zero",   12'hE00, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b1, 1, 0, 9'h0);
    applyStimulus("vgpr",           12'hA10, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b1, 1, 0, 9'h0);

    // Specials with a patterned vcc and exec=0
    vcc  = 64'h89AB_CDEF_0123_4567;
    exec = 64'h0;
    applyStimulus("vcc_lo",         12'hE01, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0000_0000_0123_4567, 1'b0, 1, 0, 9'h0);
    applyStimulus("vcc_lo wide",    12'hE01, 1'b1, FP_NONE, 1'b0, 32'h0, 64'h89AB_CDEF_0123_4567, 1'b0, 1, 0, 9'h0);
    applyStimulus("vcc_hi",         12'hE02, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0000_0000_89AB_CDEF, 1'b0, 1, 0, 9'h0);
    applyStimulus("vcc_hi wide",    12'hE02, 1'b1, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b1, 1, 0, 9'h0);
    applyStimulus("m0",             12'hE04, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0000_0000_CAFE_F00D, 1'b0, 1, 0, 9'h0);
    applyStimulus("m0 wide",        12'hE04, 1'b1, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b1, 1, 0, 9'h0);
    applyStimulus("exec_hi wide",   12'hE10, 1'b1, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b1, 1, 0, 9'h0);
    applyStimulus("execz zero",     12'hE40, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h1, 1'b0, 1, 0, 9'h0);
    applyStimulus("vccz nonzero",   12'hE20, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b0, 1, 0, 9'h0);

    // FP constant / literal / marker errors
    applyStimulus("fp const",       12'h7FF, 1'b0, FP_ONE,  1'b0, 32'h0, 64'h3F80_0000, 1'b0, 1, 0, 9'h0);
    applyStimulus("fp const wide",  12'h7FF, 1'b1, FP_ONE,  1'b0, 32'h0, 64'h3F80_0000, 1'b0, 1, 0, 9'h0);
    applyStimulus("literal",        12'h7FF, 1'b0, FP_ONE,  1'b1, 32'h1234_5678, 64'h1234_5678, 1'b0, 1, 0, 9'h0);
    applyStimulus("no fp no lit",   12'h7FF, 1'b0, FP_NONE, 1'b0, 32'h1234_5678, 64'h0, 1'b1, 1, 0, 9'h0);
    applyStimulus("prefix 01",      12'h400, 1'b0, FP_ONE,  1'b1, 32'h1234_5678, 64'h0, 1'b1, 1, 0, 9'h0);

    // Backpressure: the response must wait, unchanged, for six cycles
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus("backpressure",   12'h005, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h5, 1'b0, 1, 0, 9'h0);
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;

    // Reset while waiting for SGPR data: nothing must come back
    applyStimulus("reset in wait",  12'hC07, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0, 1'b0, LAT + 2, 1, 9'h007);
    @(negedge clk);
    exp_data_q.delete();
    exp_err_q.delete();
    exp_cyc_q.delete();
    exp_name_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post-reset rsp_valid", {63'h0, rsp_valid},  64'h0);
    checkOutput("post-reset req_ready", {63'h0, req_ready},  64'h1);
    checkOutput("post-reset rsp_data",  rsp_data,            64'h0);
    repeat (4) @(negedge clk);

    // Normal operation resumes after the aborted read
    applyStimulus("sgpr after reset", 12'hC07, 1'b0, FP_NONE, 1'b0, 32'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, LAT + 2, 1, 9'h007);

    guard = 0;
    while ((exp_data_q.size() != 0 || rd_addr_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    if (exp_data_q.size() != 0 || rd_addr_q.size() != 0) begin
      tests_run++;
      failed++;
      $display("[TB] FAIL drain: %0d responses and %0d reads outstanding, required 0",
               exp_data_q.size(), rd_addr_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
